activation_cache: RTL and testbench

//  Dilated causal tap buffer. Feeds the four packed_a0..a3 tap inputs of a conv1d layer.

---
 rtl/activation_cache_pkg.sv | 18 +
 rtl/activation_cache.sv | 109 ++++++++++
 tb/tb_activation_cache.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/activation_cache_pkg.sv
// Shared types and helpers for the dilated causal tap buffer.
// Holds the FSM state type, the tap count and the ring index wrap helper.
package activation_cache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GATHER  = 2'd1,
      PRESENT = 2'd2
   } state_e;

   localparam int NUM_TAPS = 4;

   // Ring index n stepped back by off slots, wrapping without a modulo.
   function automatic int wrap_sub(input int n, input int off, input int l);
      return (n >= off) ? (n - off) : (n + l - off);
   endfunction

endpackage

// File: rtl/activation_cache.sv
// Dilated causal tap buffer: rings incoming activation vectors and presents
// x[t-3*DIL], x[t-2*DIL], x[t-DIL], x[t] as registered packed taps.
module activation_cache
   import activation_cache_pkg::*;
#(
   parameter int W        = 16,
   parameter int D        = 4,
   parameter int DILATION = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [D*W-1:0]   inp,
   input  logic             inp_v,
   output logic [D*W-1:0]   packed_a0,
   output logic [D*W-1:0]   packed_a1,
   output logic [D*W-1:0]   packed_a2,
   output logic [D*W-1:0]   packed_a3,
   output logic             out_v,
   output logic             primed,
   output logic             dropped
);

   localparam int L  = 3 * DILATION + 1;
   localparam int PW = $clog2(L);
   localparam int FW = $clog2(L + 1);
   localparam int DW = D * W;

   state_e          state_q, state_d;
   logic [DW-1:0]   mem_q   [0:L-1];
   logic [DW-1:0]   tap_q   [0:NUM_TAPS-1];
   logic [DW-1:0]   tap_rd  [0:NUM_TAPS-1];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   newest_q;
   logic [FW-1:0]   fill_q;
   logic            out_v_q;
   logic            primed_q;
   logic            dropped_q;
   logic            accept;
   logic            overflow;

   always_comb begin
      accept   = (state_q == IDLE) && inp_v;
      overflow = (state_q != IDLE) && inp_v;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (inp_v) state_d = GATHER;
         GATHER:  state_d = PRESENT;
         PRESENT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Tap k looks back (3-k)*DILATION slots from the newest entry; tap 0 lands
   // on the slot wr_ptr now points at, i.e. the oldest sample in the ring.
   generate
      for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
         localparam int OFF = (NUM_TAPS - 1 - gi) * DILATION;
         logic [PW-1:0] rd_idx;
         assign rd_idx     = PW'(wrap_sub(int'(newest_q), OFF, L));
         assign tap_rd[gi] = mem_q[rd_idx];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < L; i++) mem_q[i] <= '0;
         for (int k = 0; k < NUM_TAPS; k++) tap_q[k] <= '0;
         wr_ptr_q  <= '0;
         newest_q  <= '0;
         fill_q    <= '0;
         out_v_q   <= 1'b0;
         primed_q  <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         if (overflow) dropped_q <= 1'b1;
         if (accept) begin
            mem_q[wr_ptr_q] <= inp;
            newest_q        <= wr_ptr_q;
            wr_ptr_q        <= (wr_ptr_q == PW'(L - 1)) ? '0 : wr_ptr_q + 1'b1;
            out_v_q         <= 1'b0;
            if (fill_q != FW'(L)) fill_q <= fill_q + 1'b1;
         end
         if (state_q == GATHER) begin
            for (int k = 0; k < NUM_TAPS; k++) tap_q[k] <= tap_rd[k];
         end
         if (state_q == PRESENT) begin
            out_v_q  <= 1'b1;
            primed_q <= (fill_q == FW'(L));
         end
      end
   end

   assign packed_a0 = tap_q[0];
   assign packed_a1 = tap_q[1];
   assign packed_a2 = tap_q[2];
   assign packed_a3 = tap_q[3];
   assign out_v     = out_v_q;
   assign primed    = primed_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_activation_cache.sv
// Self-checking bench for activation_cache: a DILATION=2 and a DILATION=1
// instance (D=2) checked against a sample-history reference model.
module tb_activation_cache;

   localparam int W  = 16;
   localparam int D  = 2;
   localparam int DW = D * W;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] inp2, inp1;
   logic          inp_v2, inp_v1;
   logic [DW-1:0] a2_0, a2_1, a2_2, a2_3;
   logic [DW-1:0] a1_0, a1_1, a1_2, a1_3;
   logic          ov2, pr2, dr2, ov1, pr1, dr1;

   always #5 clk = ~clk;

   activation_cache #(.W(W), .D(D), .DILATION(2)) u_dil2 (
      .clk(clk), .rst(rst), .inp(inp2), .inp_v(inp_v2),
      .packed_a0(a2_0), .packed_a1(a2_1), .packed_a2(a2_2), .packed_a3(a2_3),
      .out_v(ov2), .primed(pr2), .dropped(dr2)
   );

   activation_cache #(.W(W), .D(D), .DILATION(1)) u_dil1 (
      .clk(clk), .rst(rst), .inp(inp1), .inp_v(inp_v1),
      .packed_a0(a1_0), .packed_a1(a1_1), .packed_a2(a1_2), .packed_a3(a1_3),
      .out_v(ov1), .primed(pr1), .dropped(dr1)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] hist2[$];
   logic [DW-1:0] hist1[$];
   bit            drop2_m, drop1_m;

   typedef struct {
      int sel;
      int n;
      int e0, e1, e2, e3;
      bit primed;
   } vec_t;

   // Sample k = {k.0, -k.0}: ch0 = k<<12, ch1 = its two's complement.
   function automatic logic [DW-1:0] mk(input int k);
      logic [15:0] a;
      logic [15:0] b;
      a = 16'(k << 12);
      b = ~a + 16'd1;
      return {a, b};
   endfunction

   function automatic int dil_of(input int sel);
      return (sel == 0) ? 2 : 1;
   endfunction

   function automatic logic [DW-1:0] exp_tap(input int sel, input int k);
      int n, idx;
      n   = (sel == 0) ? hist2.size() : hist1.size();
      idx = n - 1 - (3 - k) * dil_of(sel);
      if (idx < 0) return '0;
      return (sel == 0) ? hist2[idx] : hist1[idx];
   endfunction

   function automatic bit exp_primed(input int sel);
      int n;
      n = (sel == 0) ? hist2.size() : hist1.size();
      return n >= 3 * dil_of(sel) + 1;
   endfunction

   function automatic logic [DW-1:0] act_tap(input int sel, input int k);
      if (sel == 0) begin
         case (k)
            0: return a2_0;
            1: return a2_1;
            2: return a2_2;
            default: return a2_3;
         endcase
      end
      case (k)
         0: return a1_0;
         1: return a1_1;
         2: return a1_2;
         default: return a1_3;
      endcase
   endfunction

   function automatic logic act_ov(input int sel);
      return (sel == 0) ? ov2 : ov1;
   endfunction
   function automatic logic act_pr(input int sel);
      return (sel == 0) ? pr2 : pr1;
   endfunction
   function automatic logic act_dr(input int sel);
      return (sel == 0) ? dr2 : dr1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic [DW-1:0] val, input logic v);
      if (sel == 0) begin inp2 = val; inp_v2 = v; end
      else          begin inp1 = val; inp_v1 = v; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, '0, 1'b0);
      drive(1, '0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      hist2.delete();
      hist1.delete();
      drop2_m = 1'b0;
      drop1_m = 1'b0;
   endtask

   task automatic chk_taps(input int sel, input string tag);
      for (int k = 0; k < 4; k++)
         chk($sformatf("%s_a%0d", tag, k), 64'(act_tap(sel, k)), 64'(exp_tap(sel, k)));
   endtask

   // One accepted sample; optionally a junk strobe during GATHER that must be dropped.
   task automatic send(input int sel, input logic [DW-1:0] val, input bit junk);
      drive(sel, val, 1'b1);
      @(posedge clk); #1;
      if (sel == 0) hist2.push_back(val); else hist1.push_back(val);
      if (junk) drive(sel, ~val, 1'b1); else drive(sel, '0, 1'b0);
      chk("lat_n1_outv", 64'(act_ov(sel)), 64'(0));
      @(posedge clk); #1;
      drive(sel, '0, 1'b0);
      if (junk) begin
         if (sel == 0) drop2_m = 1'b1; else drop1_m = 1'b1;
      end
      chk("lat_n2_outv", 64'(act_ov(sel)), 64'(0));
      @(posedge clk); #1;
      chk("present_outv", 64'(act_ov(sel)), 64'(1));
      chk_taps(sel, "tap");
      chk("primed", 64'(act_pr(sel)), 64'(exp_primed(sel)));
      chk("dropped", 64'(act_dr(sel)), 64'((sel == 0) ? drop2_m : drop1_m));
      $display("txn dil=%0d val=%h junk=%0b a3=%h a0=%h primed=%0b dropped=%0b",
               dil_of(sel), val, junk, act_tap(sel, 3), act_tap(sel, 0),
               act_pr(sel), act_dr(sel));
   endtask

   vec_t vt[5];

   initial begin
      rst = 1'b1;
      drive(0, '0, 1'b0);
      drive(1, '0, 1'b0);

      vt[0] = '{sel: 0, n: 1,  e0: 0, e1: 0, e2: 0,  e3: 1,  primed: 1'b0};
      vt[1] = '{sel: 0, n: 7,  e0: 1, e1: 3, e2: 5,  e3: 7,  primed: 1'b1};
      vt[2] = '{sel: 0, n: 10, e0: 4, e1: 6, e2: 8,  e3: 10, primed: 1'b1};
      vt[3] = '{sel: 1, n: 5,  e0: 2, e1: 3, e2: 4,  e3: 5,  primed: 1'b1};
      vt[4] = '{sel: 1, n: 3,  e0: 0, e1: 1, e2: 2,  e3: 3,  primed: 1'b0};

      // Reset state
      do_reset();
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 4; k++) chk("rst_tap", 64'(act_tap(s, k)), 64'(0));
         chk("rst_outv", 64'(act_ov(s)), 64'(0));
         chk("rst_primed", 64'(act_pr(s)), 64'(0));
         chk("rst_dropped", 64'(act_dr(s)), 64'(0));
      end

      // Table: fixed sample sequences with spec-derived tap values
      foreach (vt[i]) begin
         do_reset();
         for (int s = 1; s <= vt[i].n; s++) send(vt[i].sel, mk(s), 1'b0);
         chk($sformatf("vec%0d_a0", i), 64'(act_tap(vt[i].sel, 0)), 64'(mk(vt[i].e0)));
         chk($sformatf("vec%0d_a1", i), 64'(act_tap(vt[i].sel, 1)), 64'(mk(vt[i].e1)));
         chk($sformatf("vec%0d_a2", i), 64'(act_tap(vt[i].sel, 2)), 64'(mk(vt[i].e2)));
         chk($sformatf("vec%0d_a3", i), 64'(act_tap(vt[i].sel, 3)), 64'(mk(vt[i].e3)));
         chk($sformatf("vec%0d_primed", i), 64'(act_pr(vt[i].sel)), 64'(vt[i].primed));
         chk($sformatf("vec%0d_dropped", i), 64'(act_dr(vt[i].sel)), 64'(0));
      end

      // inp_v held for 3 cycles from IDLE: only the first value is kept
      do_reset();
      send(0, mk(1), 1'b0);
      send(0, mk(2), 1'b0);
      drive(0, mk(21), 1'b1);
      @(posedge clk); #1;
      hist2.push_back(mk(21));
      drive(0, mk(22), 1'b1);
      @(posedge clk); #1;
      drive(0, mk(23), 1'b1);
      @(posedge clk); #1;
      drive(0, '0, 1'b0);
      drop2_m = 1'b1;
      chk("hold3_outv", 64'(ov2), 64'(1));
      chk("hold3_a3", 64'(a2_3), 64'(mk(21)));
      chk_taps(0, "hold3");
      chk("hold3_dropped", 64'(dr2), 64'(1));
      repeat (5) @(posedge clk);
      #1;
      chk("hold3_sticky", 64'(dr2), 64'(1));
      chk("hold3_outv_held", 64'(ov2), 64'(1));
      send(0, mk(24), 1'b0);

      // Reset in GATHER after 5 samples
      do_reset();
      for (int s = 1; s <= 5; s++) send(0, mk(s), s == 3);
      drive(0, mk(6), 1'b1);
      @(posedge clk); #1;
      drive(0, '0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      hist2.delete();
      drop2_m = 1'b0;
      chk("rstmid_outv", 64'(ov2), 64'(0));
      chk("rstmid_dropped", 64'(dr2), 64'(0));
      chk("rstmid_a3", 64'(a2_3), 64'(0));
      send(0, mk(9), 1'b0);
      chk("rstmid_new_a3", 64'(a2_3), 64'(mk(9)));
      chk("rstmid_new_a0", 64'(a2_0), 64'(0));

      // Randomised traffic on both instances against the history model
      do_reset();
      for (int t = 0; t < 60; t++) begin
         int sel;
         int gap;
         sel = int'($urandom_range(0, 1));
         gap = int'($urandom_range(0, 2));
         send(sel, DW'($urandom), $urandom_range(0, 4) == 0);
         repeat (gap) @(posedge clk);
         if (gap != 0) begin
            #1;
            chk("idle_hold_outv", 64'(act_ov(sel)), 64'(1));
            chk("idle_hold_a3", 64'(act_tap(sel, 3)), 64'(exp_tap(sel, 3)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
